// File: rtl/u_ins_sequencer_if.sv
// Bus bundle for u_ins_sequencer: program load, playback control,
// instruction stream to the CPU and CPU store-capture traffic.
// master = sequencer side, slave = host / CPU side.
interface u_ins_sequencer_if #(
  parameter int INS_W = 32,
  parameter int PAD_W = 3
);
  // program load
  logic             i_u_isq_ld_valid;
  logic [INS_W-1:0] i_u_isq_ld_ins;
  logic [PAD_W-1:0] i_u_isq_ld_pad;
  logic             o_u_isq_ld_ready;
  // playback control
  logic             i_u_isq_start;
  logic             i_u_isq_loop;
  logic             i_u_isq_stop;
  logic             i_u_isq_clear;
  // instruction stream and status
  logic [INS_W-1:0] o_u_isq_ins;
  logic             o_u_isq_ins_valid;
  logic             o_u_isq_busy;
  logic             o_u_isq_done;
  logic [15:0]      o_u_isq_issued;
  // CPU store capture
  logic             i_u_isq_mem_wr;
  logic             i_u_isq_word;
  logic [31:0]      i_u_isq_data_addr;
  logic [31:0]      i_u_isq_wr_data;
  logic             o_u_isq_cap_valid;
  logic             i_u_isq_cap_ready;
  logic [64:0]      o_u_isq_cap_data;
  logic             o_u_isq_cap_ovf;

  modport master (
    input  i_u_isq_ld_valid, i_u_isq_ld_ins, i_u_isq_ld_pad,
    output o_u_isq_ld_ready,
    input  i_u_isq_start, i_u_isq_loop, i_u_isq_stop, i_u_isq_clear,
    output o_u_isq_ins, o_u_isq_ins_valid, o_u_isq_busy, o_u_isq_done, o_u_isq_issued,
    input  i_u_isq_mem_wr, i_u_isq_word, i_u_isq_data_addr, i_u_isq_wr_data,
    output o_u_isq_cap_valid,
    input  i_u_isq_cap_ready,
    output o_u_isq_cap_data, o_u_isq_cap_ovf
  );

  modport slave (
    output i_u_isq_ld_valid, i_u_isq_ld_ins, i_u_isq_ld_pad,
    input  o_u_isq_ld_ready,
    output i_u_isq_start, i_u_isq_loop, i_u_isq_stop, i_u_isq_clear,
    input  o_u_isq_ins, o_u_isq_ins_valid, o_u_isq_busy, o_u_isq_done, o_u_isq_issued,
    output i_u_isq_mem_wr, i_u_isq_word, i_u_isq_data_addr, i_u_isq_wr_data,
    input  o_u_isq_cap_valid,
    output i_u_isq_cap_ready,
    input  o_u_isq_cap_data, o_u_isq_cap_ovf
  );
endinterface

// File: rtl/u_ins_sequencer.sv
// u_ins_sequencer: loadable instruction-stream player for u_cpu's instruction port.
// Each program entry holds an instruction plus a count of NOP words issued after it.
// Playback runs once (ending in DONE) or loops until stop.
// Optional macro STORE_CAPTURE_EN adds a first-word-fall-through FIFO recording
// CPU stores as {word, addr, data}; without it the capture outputs are tied to 0.
module u_ins_sequencer #(
  parameter int               INS_W     = 32,
  parameter int               DEPTH     = 16,
  parameter int               PAD_W     = 3,
  parameter logic [INS_W-1:0] NOP_WORD  = {INS_W{1'b0}},
  parameter int               CAP_DEPTH = 8
) (
  input  logic              i_sys_clock,
  input  logic              i_sys_reset,
  u_ins_sequencer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = PAD_W + INS_W;

  typedef enum logic [1:0] {IDLE, RUN_INS, RUN_PAD, DONE} state_t;

  state_t           state_reg, state_next;
  logic [LW-1:0]    prog_len_reg, prog_len_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PAD_W-1:0] pad_cnt_reg, pad_cnt_next;
  logic             loop_reg, loop_next;
  logic [15:0]      issued_reg, issued_next;

  logic [EW-1:0]    prog_ram [DEPTH];
  logic [EW-1:0]    ram_q_reg;

  logic             ctl_state;
  logic             ld_ready;
  logic             ld_fire;
  logic             is_last;
  logic [PAD_W-1:0] cur_pad;
  logic [INS_W-1:0] cur_ins;

  // ram_q_reg always holds the entry at rd_ptr_reg, because it is read at rd_ptr_next
  assign cur_pad   = ram_q_reg[EW-1:INS_W];
  assign cur_ins   = ram_q_reg[INS_W-1:0];
  assign is_last   = ({1'b0, rd_ptr_reg} == (prog_len_reg - LW'(1)));
  assign ctl_state = (state_reg == IDLE) || (state_reg == DONE);
  assign ld_ready  = ctl_state && (prog_len_reg < LW'(DEPTH));
  // clear wins over a load presented in the same cycle
  assign ld_fire   = bus.i_u_isq_ld_valid && ld_ready && !bus.i_u_isq_clear;

  // Next-state: load/clear/start handling when idle, entry/padding walk when running
  always_comb begin
    state_next    = state_reg;
    prog_len_next = prog_len_reg;
    rd_ptr_next   = rd_ptr_reg;
    pad_cnt_next  = pad_cnt_reg;
    loop_next     = loop_reg;
    issued_next   = issued_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.i_u_isq_clear) begin
          prog_len_next = '0;
          state_next    = IDLE;
        end else begin
          if (ld_fire) begin
            prog_len_next = prog_len_reg + LW'(1);
            state_next    = IDLE;
          end
          if (bus.i_u_isq_start) begin
            if (prog_len_reg != '0) begin
              loop_next    = bus.i_u_isq_loop;
              rd_ptr_next  = '0;
              pad_cnt_next = '0;
              issued_next  = '0;
              state_next   = RUN_INS;
            end else begin
              state_next = DONE;
            end
          end
        end
      end
      RUN_INS, RUN_PAD: begin
        // every running cycle drives a valid word
        if (issued_reg != 16'hFFFF) begin
          issued_next = issued_reg + 16'd1;
        end
        if (bus.i_u_isq_stop) begin
          pad_cnt_next = '0;
          state_next   = IDLE;
        end else if ((state_reg == RUN_INS) && (cur_pad != '0)) begin
          pad_cnt_next = cur_pad;
          state_next   = RUN_PAD;
        end else if ((state_reg == RUN_PAD) && (pad_cnt_reg > PAD_W'(1))) begin
          pad_cnt_next = pad_cnt_reg - PAD_W'(1);
        end else begin
          // entry (and its padding) complete: move on, wrap, or finish
          pad_cnt_next = '0;
          if (!is_last) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
            state_next  = RUN_INS;
          end else if (loop_reg) begin
            rd_ptr_next = '0;
            state_next  = RUN_INS;
          end else begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge i_sys_clock) begin
    if (!i_sys_reset) begin
      state_reg    <= IDLE;
      prog_len_reg <= '0;
      rd_ptr_reg   <= '0;
      pad_cnt_reg  <= '0;
      loop_reg     <= 1'b0;
      issued_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      prog_len_reg <= prog_len_next;
      rd_ptr_reg   <= rd_ptr_next;
      pad_cnt_reg  <= pad_cnt_next;
      loop_reg     <= loop_next;
      issued_reg   <= issued_next;
    end
  end

  // Program RAM: append on accepted load, registered read of the entry playback needs next
  always_ff @(posedge i_sys_clock) begin
    if (ld_fire) begin
      prog_ram[prog_len_reg[AW-1:0]] <= {bus.i_u_isq_ld_pad, bus.i_u_isq_ld_ins};
    end
    ram_q_reg <= prog_ram[rd_ptr_next];
  end

  // Outputs are decoded from registers only; padding cycles and idle both show NOP_WORD
  assign bus.o_u_isq_ld_ready  = ld_ready;
  assign bus.o_u_isq_busy      = (state_reg == RUN_INS) || (state_reg == RUN_PAD);
  assign bus.o_u_isq_ins_valid = (state_reg == RUN_INS) || (state_reg == RUN_PAD);
  assign bus.o_u_isq_done      = (state_reg == DONE);
  assign bus.o_u_isq_ins       = (state_reg == RUN_INS) ? cur_ins : NOP_WORD;
  assign bus.o_u_isq_issued    = issued_reg;

`ifdef STORE_CAPTURE_EN
  localparam int CW = $clog2(CAP_DEPTH);
  localparam int NW = CW + 1;

  logic [64:0]   cap_entry [CAP_DEPTH];
  logic [CW-1:0] cap_wr_ptr_reg, cap_rd_ptr_reg;
  logic [NW-1:0] cap_cnt_reg;
  logic          cap_ovf_reg;
  logic          cap_full, cap_pop, cap_push;

  assign cap_full = (cap_cnt_reg == NW'(CAP_DEPTH));
  assign cap_pop  = (cap_cnt_reg != '0) && bus.i_u_isq_cap_ready;
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still taken
  assign cap_push = bus.i_u_isq_mem_wr && (!cap_full || cap_pop);

  // Capture storage: one register per slot, written when the write pointer selects it
  for (genvar gi = 0; gi < CAP_DEPTH; gi++) begin : g_cap_entry
    logic [64:0] entry_reg;
    always_ff @(posedge i_sys_clock) begin
      if (cap_push && (cap_wr_ptr_reg == CW'(gi))) begin
        entry_reg <= {bus.i_u_isq_word, bus.i_u_isq_data_addr, bus.i_u_isq_wr_data};
      end
    end
    assign cap_entry[gi] = entry_reg;
  end

  // Capture pointers, occupancy and sticky overflow
  always_ff @(posedge i_sys_clock) begin
    if (!i_sys_reset) begin
      cap_wr_ptr_reg <= '0;
      cap_rd_ptr_reg <= '0;
      cap_cnt_reg    <= '0;
      cap_ovf_reg    <= 1'b0;
    end else begin
      if (cap_push) begin
        cap_wr_ptr_reg <= cap_wr_ptr_reg + CW'(1);
      end
      if (cap_pop) begin
        cap_rd_ptr_reg <= cap_rd_ptr_reg + CW'(1);
      end
      if (cap_push && !cap_pop) begin
        cap_cnt_reg <= cap_cnt_reg + NW'(1);
      end else if (cap_pop && !cap_push) begin
        cap_cnt_reg <= cap_cnt_reg - NW'(1);
      end
      if (bus.i_u_isq_mem_wr && !cap_push) begin
        cap_ovf_reg <= 1'b1;
      end
    end
  end

  assign bus.o_u_isq_cap_valid = (cap_cnt_reg != '0);
  assign bus.o_u_isq_cap_data  = cap_entry[cap_rd_ptr_reg];
  assign bus.o_u_isq_cap_ovf   = cap_ovf_reg;
`else
  // capture disabled: store inputs are accepted and discarded
  logic unused_cap;
  assign unused_cap = ^{bus.i_u_isq_mem_wr, bus.i_u_isq_word, bus.i_u_isq_data_addr,
                        bus.i_u_isq_wr_data, bus.i_u_isq_cap_ready, 1'(CAP_DEPTH)};

  assign bus.o_u_isq_cap_valid = 1'b0;
  assign bus.o_u_isq_cap_data  = '0;
  assign bus.o_u_isq_cap_ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_u_ins_sequencer.sv
// Self-checking bench for u_ins_sequencer. A reference model keeps the program as a
// list of (instruction, pad) pairs and expands it into the expected word stream.
// Capture checks use a queue model when STORE_CAPTURE_EN is defined.
module tb_u_ins_sequencer;
  localparam int          INS_W = 32;
  localparam int          DEPTH = 16;
  localparam int          PAD_W = 3;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  typedef logic [64:0] cv_t;

  logic tb_i_sys_clock = 1'b0;
  logic tb_i_sys_reset;

  u_ins_sequencer_if #(.INS_W(INS_W), .PAD_W(PAD_W)) isq_bus ();

  u_ins_sequencer #(
    .INS_W(INS_W), .DEPTH(DEPTH), .PAD_W(PAD_W), .NOP_WORD(NOP), .CAP_DEPTH(8)
  ) dut (
    .i_sys_clock(tb_i_sys_clock),
    .i_sys_reset(tb_i_sys_reset),
    .bus(isq_bus)
  );

  always #5 tb_i_sys_clock = ~tb_i_sys_clock;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // reference model
  logic [31:0] m_ins[$];
  logic [2:0]  m_pad[$];
  logic [31:0] s_word[$];
  bit          s_is_ins[$];
  bit          m_done;
  cv_t         cap_q[$];
  bit          cap_ovf_m;

  task automatic check_value(input string tag, input cv_t got, input cv_t exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_i_sys_clock);
    #1;
  endtask

  // expected word stream of one pass: instruction followed by pad NOPs, per entry
  function automatic void build_stream();
    s_word.delete();
    s_is_ins.delete();
    foreach (m_ins[i]) begin
      s_word.push_back(m_ins[i]);
      s_is_ins.push_back(1'b1);
      for (int j = 0; j < int'(m_pad[i]); j++) begin
        s_word.push_back(NOP);
        s_is_ins.push_back(1'b0);
      end
    end
  endfunction

  task automatic do_reset();
    tb_i_sys_reset = 1'b0;
    tick();
    tb_i_sys_reset = 1'b1;
    m_ins.delete();
    m_pad.delete();
    m_done    = 1'b0;
    cap_q.delete();
    cap_ovf_m = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_value({tag, "_busy"}, cv_t'(isq_bus.o_u_isq_busy), cv_t'(0));
    check_value({tag, "_valid"}, cv_t'(isq_bus.o_u_isq_ins_valid), cv_t'(0));
    check_value({tag, "_ins"}, cv_t'(isq_bus.o_u_isq_ins), cv_t'(NOP));
    check_value({tag, "_done"}, cv_t'(isq_bus.o_u_isq_done), cv_t'(m_done));
  endtask

  task automatic load_word(input logic [31:0] w, input logic [2:0] p);
    bit ok;
    ok = (m_ins.size() < DEPTH);
    check_value("ld_ready", cv_t'(isq_bus.o_u_isq_ld_ready), cv_t'(ok));
    isq_bus.i_u_isq_ld_valid = 1'b1;
    isq_bus.i_u_isq_ld_ins   = w;
    isq_bus.i_u_isq_ld_pad   = p;
    tick();
    isq_bus.i_u_isq_ld_valid = 1'b0;
    if (ok) begin
      m_ins.push_back(w);
      m_pad.push_back(p);
      m_done = 1'b0;
    end
    check_value("load_done", cv_t'(isq_bus.o_u_isq_done), cv_t'(m_done));
    $display("load: ins=%08h pad=%0d accepted=%0d len=%0d", w, p, ok, m_ins.size());
  endtask

  task automatic clear_prog();
    isq_bus.i_u_isq_clear = 1'b1;
    tick();
    isq_bus.i_u_isq_clear = 1'b0;
    m_ins.delete();
    m_pad.delete();
    m_done = 1'b0;
    check_idle("clear");
    check_value("clear_ld_ready", cv_t'(isq_bus.o_u_isq_ld_ready), cv_t'(1));
    $display("clear: program emptied");
  endtask

  // start playback, observe n_obs words; optionally stop on the last observed word,
  // and optionally poke start/clear during instruction cycles (both must be ignored)
  task automatic run_program(input bit loop_en, input int n_obs, input bit do_stop,
                             input bit poke_en);
    int slen;
    int idx;
    build_stream();
    slen = s_word.size();
    isq_bus.i_u_isq_loop  = loop_en;
    isq_bus.i_u_isq_start = 1'b1;
    tick();
    isq_bus.i_u_isq_start = 1'b0;
    isq_bus.i_u_isq_loop  = 1'b0;
    for (int k = 0; k < n_obs; k++) begin
      idx = k % slen;
      check_value("run_ins", cv_t'(isq_bus.o_u_isq_ins), cv_t'(s_word[idx]));
      check_value("run_valid", cv_t'(isq_bus.o_u_isq_ins_valid), cv_t'(1));
      check_value("run_busy", cv_t'(isq_bus.o_u_isq_busy), cv_t'(1));
      check_value("run_ld_ready", cv_t'(isq_bus.o_u_isq_ld_ready), cv_t'(0));
      if (poke_en && s_is_ins[idx]) begin
        if (k == 0) isq_bus.i_u_isq_start = 1'b1;
        else        isq_bus.i_u_isq_clear = 1'b1;
      end
      if (do_stop && (k == n_obs - 1)) isq_bus.i_u_isq_stop = 1'b1;
      tick();
      isq_bus.i_u_isq_start = 1'b0;
      isq_bus.i_u_isq_clear = 1'b0;
      isq_bus.i_u_isq_stop  = 1'b0;
    end
    m_done = !do_stop;
    check_idle("end");
    check_value("end_issued", cv_t'(isq_bus.o_u_isq_issued), cv_t'(n_obs));
    $display("run: loop=%0d entries=%0d words=%0d stop=%0d poke=%0d",
             loop_en, m_ins.size(), n_obs, do_stop, poke_en);
  endtask

`ifdef STORE_CAPTURE_EN
  task automatic cap_cycle(input bit wr, input cv_t d, input bit rd);
    bit pop_ok;
    bit push_ok;
    pop_ok  = rd && (cap_q.size() > 0);
    push_ok = wr && ((cap_q.size() < 8) || pop_ok);
    isq_bus.i_u_isq_mem_wr    = wr;
    isq_bus.i_u_isq_word      = d[64];
    isq_bus.i_u_isq_data_addr = d[63:32];
    isq_bus.i_u_isq_wr_data   = d[31:0];
    isq_bus.i_u_isq_cap_ready = rd;
    tick();
    isq_bus.i_u_isq_mem_wr    = 1'b0;
    isq_bus.i_u_isq_cap_ready = 1'b0;
    if (pop_ok) void'(cap_q.pop_front());
    if (push_ok) cap_q.push_back(d);
    if (wr && !push_ok) cap_ovf_m = 1'b1;
    check_value("cap_valid", cv_t'(isq_bus.o_u_isq_cap_valid), cv_t'(cap_q.size() > 0));
    check_value("cap_ovf", cv_t'(isq_bus.o_u_isq_cap_ovf), cv_t'(cap_ovf_m));
    if (cap_q.size() > 0) begin
      check_value("cap_head", isq_bus.o_u_isq_cap_data, cap_q[0]);
    end
    $display("cap: wr=%0d rd=%0d data=%017h level=%0d ovf=%0d", wr, rd, d, cap_q.size(), cap_ovf_m);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int slen;
    bit lp;
    isq_bus.i_u_isq_ld_valid  = 1'b0;
    isq_bus.i_u_isq_ld_ins    = '0;
    isq_bus.i_u_isq_ld_pad    = '0;
    isq_bus.i_u_isq_start     = 1'b0;
    isq_bus.i_u_isq_loop      = 1'b0;
    isq_bus.i_u_isq_stop      = 1'b0;
    isq_bus.i_u_isq_clear     = 1'b0;
    isq_bus.i_u_isq_mem_wr    = 1'b0;
    isq_bus.i_u_isq_word      = 1'b0;
    isq_bus.i_u_isq_data_addr = '0;
    isq_bus.i_u_isq_wr_data   = '0;
    isq_bus.i_u_isq_cap_ready = 1'b0;
    tb_i_sys_reset            = 1'b0;
    tick();
    do_reset();

    // reset state
    check_idle("rst");
    check_value("rst_issued", cv_t'(isq_bus.o_u_isq_issued), cv_t'(0));
    check_value("rst_ld_ready", cv_t'(isq_bus.o_u_isq_ld_ready), cv_t'(1));
    check_value("rst_cap_valid", cv_t'(isq_bus.o_u_isq_cap_valid), cv_t'(0));
    check_value("rst_cap_ovf", cv_t'(isq_bus.o_u_isq_cap_ovf), cv_t'(0));

    // two-entry single pass with padding
    load_word(32'h3408_04D2, 3'd3);
    load_word(32'h0100_4822, 3'd0);
    run_program(1'b0, 5, 1'b0, 1'b0);

    // full program, rejected 17th load, 16-word playback
    clear_prog();
    for (int i = 0; i < DEPTH; i++) load_word($urandom(), 3'd0);
    check_value("full_ld_ready", cv_t'(isq_bus.o_u_isq_ld_ready), cv_t'(0));
    load_word(32'hDEAD_BEEF, 3'd2);
    run_program(1'b0, 16, 1'b0, 1'b0);
    load_word(32'h1234_5678, 3'd1);

    // looping pattern, stop on the 7th word
    clear_prog();
    load_word(32'h3C0F_03E8, 3'd0);
    load_word(32'h3C0A_1234, 3'd1);
    run_program(1'b1, 7, 1'b1, 1'b0);

    // empty program: straight to DONE, never valid
    clear_prog();
    isq_bus.i_u_isq_start = 1'b1;
    tick();
    isq_bus.i_u_isq_start = 1'b0;
    m_done = 1'b1;
    check_idle("empty");
    tick();
    check_idle("empty2");
    $display("run: empty program start");

    // reset while padding
    load_word(32'h2402_0005, 3'd5);
    isq_bus.i_u_isq_start = 1'b1;
    tick();
    isq_bus.i_u_isq_start = 1'b0;
    check_value("pad_ins", cv_t'(isq_bus.o_u_isq_ins), cv_t'(32'h2402_0005));
    tick();
    check_value("pad_valid", cv_t'(isq_bus.o_u_isq_ins_valid), cv_t'(1));
    check_value("pad_nop", cv_t'(isq_bus.o_u_isq_ins), cv_t'(NOP));
    do_reset();
    check_idle("midrst");
    check_value("midrst_ld_ready", cv_t'(isq_bus.o_u_isq_ld_ready), cv_t'(1));
    check_value("midrst_issued", cv_t'(isq_bus.o_u_isq_issued), cv_t'(0));
    isq_bus.i_u_isq_start = 1'b1;
    tick();
    isq_bus.i_u_isq_start = 1'b0;
    m_done = 1'b1;
    check_idle("lost_prog");
    $display("run: reset during padding");

    // start and clear during instruction cycles are ignored; program survives
    clear_prog();
    load_word(32'h2008_0001, 3'd1);
    load_word(32'h2109_0002, 3'd0);
    load_word(32'hAC0A_0004, 3'd2);
    run_program(1'b0, 6, 1'b0, 1'b1);
    run_program(1'b0, 6, 1'b0, 1'b0);

    // randomized programs
    for (int it = 0; it < 8; it++) begin
      clear_prog();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) load_word($urandom(), 3'($urandom_range(0, 7)));
      build_stream();
      slen = s_word.size();
      lp = 1'($urandom_range(0, 1));
      if (lp) run_program(1'b1, $urandom_range(1, 3 * slen), 1'b1, 1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 2) == 0) run_program(1'b0, $urandom_range(1, slen), 1'b1, 1'b0);
      else run_program(1'b0, slen, 1'b0, 1'($urandom_range(0, 1)));
    end

`ifdef STORE_CAPTURE_EN
    cap_cycle(1'b1, {1'b1, 32'h03E8_0000, 32'h1234_1E61}, 1'b0);
    cap_cycle(1'b1, {1'b0, 32'h03E8_0001, 32'h0000_003A}, 1'b0);
    cap_cycle(1'b0, '0, 1'b1);
    cap_cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 9; i++) cap_cycle(1'b1, {1'($urandom()), $urandom(), $urandom()}, 1'b0);
    clear_prog();
    check_value("cap_after_clear", cv_t'(isq_bus.o_u_isq_cap_valid), cv_t'(1));
    cap_cycle(1'b1, {1'b1, $urandom(), $urandom()}, 1'b1);
    for (int i = 0; i < 8; i++) cap_cycle(1'b0, '0, 1'b1);
    do_reset();
    check_value("cap_rst_ovf", cv_t'(isq_bus.o_u_isq_cap_ovf), cv_t'(0));
    check_value("cap_rst_valid", cv_t'(isq_bus.o_u_isq_cap_valid), cv_t'(0));
`else
    isq_bus.i_u_isq_mem_wr    = 1'b1;
    isq_bus.i_u_isq_word      = 1'b1;
    isq_bus.i_u_isq_data_addr = 32'h03E8_0000;
    isq_bus.i_u_isq_wr_data   = 32'h1234_1E61;
    isq_bus.i_u_isq_cap_ready = 1'b1;
    tick();
    tick();
    isq_bus.i_u_isq_mem_wr    = 1'b0;
    isq_bus.i_u_isq_cap_ready = 1'b0;
    check_value("nocap_valid", cv_t'(isq_bus.o_u_isq_cap_valid), cv_t'(0));
    check_value("nocap_data", isq_bus.o_u_isq_cap_data, cv_t'(0));
    check_value("nocap_ovf", cv_t'(isq_bus.o_u_isq_cap_ovf), cv_t'(0));
    $display("cap: capture disabled, store strobes ignored");
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
